// File: rtl/axi_sram_slave.sv
// AXI3-subset responder over an internal word SRAM.
// Independent read/write FSMs, INCR/FIXED bursts, DECERR/SLVERR reporting.
module axi_sram_slave #(
  parameter int          ADDR_W = 16,
  parameter logic [31:0] BASE   = 32'h1c00_0000,
  parameter int          RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [32:0] WIN    = 33'd4 << ADDR_W;
  localparam logic [3:0]  LAT_M1 = 4'(RD_LAT > 0 ? RD_LAT - 1 : 0);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  function automatic logic in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return {1'b0, off} < WIN;
  endfunction

  function automatic logic [ADDR_W-1:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[ADDR_W+1:2];
  endfunction

  function automatic logic [31:0] nxt(
    input logic [31:0] a,
    input logic [2:0]  sz,
    input logic [1:0]  bu
  );
    return (bu == 2'b00) ? a : a + (32'd1 << sz);
  endfunction

  logic        unused_wid;
  assign unused_wid = ^wid;

  // ---------------- read channel ----------------
  logic [1:0]  r_state_q;
  logic [3:0]  r_id_q;
  logic [31:0] r_addr_q;
  logic [7:0]  r_len_q;
  logic [2:0]  r_size_q;
  logic [1:0]  r_burst_q;
  logic [7:0]  r_cnt_q;
  logic [3:0]  r_lat_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic        r_ld_d;
  logic [31:0] r_ld_addr_d;
  logic [7:0]  r_ld_cnt_d;
  logic [7:0]  r_ld_len_d;

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = rvalid_q;
  assign rid     = r_id_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

  // Decide when a beat is loaded into the R output registers, and from where.
  always_comb begin
    r_ld_d      = 1'b0;
    r_ld_addr_d = r_addr_q;
    r_ld_cnt_d  = r_cnt_q;
    r_ld_len_d  = r_len_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && RD_LAT == 0) begin
          r_ld_d      = 1'b1;
          r_ld_addr_d = araddr;
          r_ld_cnt_d  = 8'd0;
          r_ld_len_d  = arlen;
        end
      end
      R_WAIT: begin
        if (r_lat_q == LAT_M1) begin
          r_ld_d     = 1'b1;
          r_ld_cnt_d = 8'd0;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready && !rlast_q) begin
          r_ld_d      = 1'b1;
          r_ld_addr_d = nxt(r_addr_q, r_size_q, r_burst_q);
          r_ld_cnt_d  = 8'(r_cnt_q + 8'd1);
        end
      end
      default: ;
    endcase
  end

  // Read FSM and registered R beat (memory sampled when a beat loads).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= 4'd0;
      r_addr_q  <= 32'd0;
      r_len_q   <= 8'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      r_cnt_q   <= 8'd0;
      r_lat_q   <= 4'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'd0;
      rlast_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arvalid) begin
            r_id_q    <= arid;
            r_addr_q  <= araddr;
            r_len_q   <= arlen;
            r_size_q  <= arsize;
            r_burst_q <= arburst;
            r_cnt_q   <= 8'd0;
            r_lat_q   <= 4'd0;
            r_state_q <= (RD_LAT == 0) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          r_lat_q <= r_lat_q + 4'd1;
          if (r_ld_d) r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (rvalid_q && rready && rlast_q) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
      if (r_ld_d) begin
        r_addr_q <= r_ld_addr_d;
        r_cnt_q  <= r_ld_cnt_d;
        rvalid_q <= 1'b1;
        rlast_q  <= (r_ld_cnt_d == r_ld_len_d);
        if (in_rng(r_ld_addr_d)) begin
          rdata_q <= mem[widx(r_ld_addr_d)];
          rresp_q <= 2'b00;
        end else begin
          rdata_q <= 32'd0;
          rresp_q <= 2'b11;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  logic [1:0]  w_state_q;
  logic [31:0] w_addr_q;
  logic [7:0]  w_len_q;
  logic [2:0]  w_size_q;
  logic [1:0]  w_burst_q;
  logic [7:0]  w_cnt_q;
  logic        w_dec_q;
  logic        w_slv_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;

  logic w_hs, w_in, w_end, w_dec_d, w_slv_d;

  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = bresp_q;

  assign w_hs    = wvalid && wready;
  assign w_in    = in_rng(w_addr_q);
  assign w_end   = (w_cnt_q == w_len_q);
  assign w_dec_d = w_dec_q | ~w_in;
  assign w_slv_d = w_slv_q | (wlast != w_end);

  // Write FSM: accept AW, count beats by awlen, then hold B until bready.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= 32'd0;
      w_len_q   <= 8'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      w_cnt_q   <= 8'd0;
      w_dec_q   <= 1'b0;
      w_slv_q   <= 1'b0;
      bid_q     <= 4'd0;
      bresp_q   <= 2'd0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awvalid) begin
            w_addr_q  <= awaddr;
            w_len_q   <= awlen;
            w_size_q  <= awsize;
            w_burst_q <= awburst;
            w_cnt_q   <= 8'd0;
            w_dec_q   <= 1'b0;
            w_slv_q   <= 1'b0;
            bid_q     <= awid;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_dec_q <= w_dec_d;
            w_slv_q <= w_slv_d;
            if (w_end) begin
              w_state_q <= W_RESP;
              bresp_q   <= w_dec_d ? 2'b11 : (w_slv_d ? 2'b10 : 2'b00);
            end else begin
              w_cnt_q  <= 8'(w_cnt_q + 8'd1);
              w_addr_q <= nxt(w_addr_q, w_size_q, w_burst_q);
            end
          end
        end
        W_RESP: begin
          if (bready) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Byte-masked memory write for in-range W beats; storage is never cleared.
  always_ff @(posedge clock) begin
    if (!reset && w_hs && w_in) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[widx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed bursts, timing,
// backpressure, strobes, error responses and mid-burst reset.
module tb_axi_sram_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid = 0, arready;
  logic [3:0]  arid = 0;
  logic [31:0] araddr = 0;
  logic [7:0]  arlen = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 1;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        awvalid = 0, awready;
  logic [3:0]  awid = 0;
  logic [31:0] awaddr = 0;
  logic [7:0]  awlen = 0;
  logic [2:0]  awsize = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready;
  logic [3:0]  wid = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bvalid, bready = 1;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  axi_sram_slave dut (
    .clock(clock), .reset(reset),
    .arvalid(arvalid), .arready(arready), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid),
    .bresp(bresp)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rexp[$];
  bexp_t bexp[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Monitor: pops an expectation for each handshake about to occur.
  always @(negedge clock) begin
    rexp_t re;
    bexp_t be;
    if (!reset) begin
      if (rvalid && rready) begin
        if (rexp.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = rexp.pop_front();
          chk("rid", 32'(rid), 32'(re.id));
          chk("rdata", rdata, re.data);
          chk("rresp", 32'(rresp), 32'(re.resp));
          chk("rlast", 32'(rlast), 32'(re.last));
        end
      end
      if (bvalid && bready) begin
        if (bexp.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = bexp.pop_front();
          chk("bid", 32'(bid), 32'(be.id));
          chk("bresp", 32'(bresp), 32'(be.resp));
        end
      end
    end
  end

  task automatic er(input logic [3:0] id, input logic [31:0] d,
                    input logic [1:0] rs, input logic l);
    rexp_t e;
    e.id = id; e.data = d; e.resp = rs; e.last = l;
    rexp.push_back(e);
  endtask

  task automatic eb(input logic [3:0] id, input logic [1:0] rs);
    bexp_t e;
    e.id = id; e.resp = rs;
    bexp.push_back(e);
  endtask

  task automatic ar(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] l, input logic [2:0] s,
                    input logic [1:0] b);
    int n = 0;
    arvalid = 1; arid = id; araddr = a;
    arlen = l; arsize = s; arburst = b;
    @(negedge clock);
    while (!arready && n < 100) begin @(negedge clock); n++; end
    if (!arready) chk("ar_timeout", 0, 1);
    @(posedge clock); #1 arvalid = 0;
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] l, input logic [2:0] s,
                    input logic [1:0] b);
    int n = 0;
    awvalid = 1; awid = id; awaddr = a;
    awlen = l; awsize = s; awburst = b;
    @(negedge clock);
    while (!awready && n < 100) begin @(negedge clock); n++; end
    if (!awready) chk("aw_timeout", 0, 1);
    @(posedge clock); #1 awvalid = 0;
  endtask

  task automatic wb(input logic [31:0] d, input logic [3:0] s,
                    input logic l);
    int n = 0;
    wvalid = 1; wdata = d; wstrb = s; wlast = l;
    @(negedge clock);
    while (!wready && n < 100) begin @(negedge clock); n++; end
    if (!wready) chk("w_timeout", 0, 1);
    @(posedge clock); #1 wvalid = 0; wlast = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((rexp.size() != 0 || bexp.size() != 0) && n < 500) begin
      @(posedge clock); #1; n++;
    end
    chk("drain", 32'(rexp.size() + bexp.size()), 0);
    cyc(1);
  endtask

  localparam logic [31:0] B = 32'h1c00_0000;

  initial begin
    cyc(3);
    reset = 0;
    // reset state
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_awready", 32'(awready), 1);

    // INCR write burst then read back
    eb(4'd1, 2'b00);
    aw(4'd1, B + 32'h10, 8'd3, 3'd2, 2'b01);
    wb(32'h11, 4'hf, 0);
    wb(32'h22, 4'hf, 0);
    wb(32'h33, 4'hf, 0);
    wb(32'h44, 4'hf, 1);
    drain();
    er(4'd1, 32'h11, 0, 0); er(4'd1, 32'h22, 0, 0);
    er(4'd1, 32'h33, 0, 0); er(4'd1, 32'h44, 0, 1);
    ar(4'd1, B + 32'h10, 8'd3, 3'd2, 2'b01);
    drain();

    // RD_LAT=1 timing on a single-beat read
    er(4'd3, 32'h11, 0, 1);
    arvalid = 1; arid = 3; araddr = B + 32'h10;
    arlen = 0; arsize = 2; arburst = 1;
    @(posedge clock); #1 arvalid = 0;
    chk("lat_rvalid_t1", 32'(rvalid), 0);
    chk("lat_arready_t1", 32'(arready), 0);
    cyc(1);
    chk("lat_rvalid_t2", 32'(rvalid), 1);
    chk("lat_arready_t2", 32'(arready), 0);
    cyc(1);
    chk("lat_rvalid_t3", 32'(rvalid), 0);
    chk("lat_arready_t3", 32'(arready), 1);
    drain();

    // narrow INCR read: byte steps stay in the containing word
    er(4'd4, 32'h11, 0, 0); er(4'd4, 32'h11, 0, 0);
    er(4'd4, 32'h11, 0, 0); er(4'd4, 32'h11, 0, 0);
    er(4'd4, 32'h22, 0, 1);
    ar(4'd4, B + 32'h10, 8'd4, 3'd0, 2'b01);
    drain();

    // R backpressure on beat 2
    er(4'd5, 32'h11, 0, 0); er(4'd5, 32'h22, 0, 0);
    er(4'd5, 32'h33, 0, 0); er(4'd5, 32'h44, 0, 1);
    ar(4'd5, B + 32'h10, 8'd3, 3'd2, 2'b01);
    begin
      int n = 0;
      @(negedge clock);
      while (!rvalid && n < 50) begin @(negedge clock); n++; end
    end
    @(posedge clock); #1 rready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("bp_rvalid", 32'(rvalid), 1);
      chk("bp_rdata", rdata, 32'h22);
      chk("bp_rlast", 32'(rlast), 0);
    end
    rready = 1;
    drain();

    // B backpressure while preloading a word
    bready = 0;
    eb(4'd6, 2'b00);
    aw(4'd6, B + 32'h100, 8'd0, 3'd2, 2'b01);
    wb(32'hAABB_CCDD, 4'hf, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bhold_bvalid", 32'(bvalid), 1);
      chk("bhold_bid", 32'(bid), 6);
      cyc(1);
    end
    bready = 1;
    drain();

    // byte strobes
    eb(4'd7, 2'b00);
    aw(4'd7, B + 32'h100, 8'd0, 3'd2, 2'b01);
    wb(32'h1122_3344, 4'b0101, 1);
    drain();
    er(4'd7, 32'hAA22_CC44, 0, 1);
    ar(4'd7, B + 32'h100, 8'd0, 3'd2, 2'b01);
    drain();

    // out-of-range read
    er(4'd2, 32'h0, 2'b11, 1);
    ar(4'd2, 32'h0, 8'd0, 3'd2, 2'b01);
    drain();

    // wlast mismatch: SLVERR, both beats committed
    eb(4'd8, 2'b10);
    aw(4'd8, B + 32'h200, 8'd1, 3'd2, 2'b01);
    wb(32'h55, 4'hf, 1);
    wb(32'h66, 4'hf, 0);
    drain();
    er(4'd8, 32'h55, 0, 0); er(4'd8, 32'h66, 0, 1);
    ar(4'd8, B + 32'h200, 8'd1, 3'd2, 2'b01);
    drain();

    // DECERR outranks SLVERR
    eb(4'd9, 2'b11);
    aw(4'd9, 32'h0, 8'd0, 3'd2, 2'b01);
    wb(32'hDEAD, 4'hf, 0);
    drain();

    // window edge: last word in range, next word out
    eb(4'd10, 2'b11);
    aw(4'd10, B + 32'h3_fffc, 8'd1, 3'd2, 2'b01);
    wb(32'h99, 4'hf, 0);
    wb(32'hAA, 4'hf, 1);
    drain();
    er(4'd10, 32'h99, 0, 0); er(4'd10, 32'h0, 2'b11, 1);
    ar(4'd10, B + 32'h3_fffc, 8'd1, 3'd2, 2'b01);
    drain();

    // FIXED bursts
    eb(4'd11, 2'b00);
    aw(4'd11, B + 32'h300, 8'd1, 3'd2, 2'b00);
    wb(32'h77, 4'hf, 0);
    wb(32'h88, 4'hf, 1);
    drain();
    er(4'd11, 32'h88, 0, 0); er(4'd11, 32'h88, 0, 0);
    er(4'd11, 32'h88, 0, 1);
    ar(4'd11, B + 32'h300, 8'd2, 3'd2, 2'b00);
    drain();

    // reset during beat 2 of 4
    er(4'd12, 32'h11, 0, 0);
    ar(4'd12, B + 32'h10, 8'd3, 3'd2, 2'b01);
    begin
      int n = 0;
      @(negedge clock);
      while (!rvalid && n < 50) begin @(negedge clock); n++; end
    end
    @(posedge clock); #1;
    reset = 1; rready = 0;
    cyc(1);
    reset = 0; rready = 1;
    chk("rst_mid_rvalid", 32'(rvalid), 0);
    chk("rst_mid_arready", 32'(arready), 1);
    rexp.delete();
    er(4'd13, 32'h22, 0, 1);
    ar(4'd13, B + 32'h14, 8'd0, 3'd2, 2'b01);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want done");
    $fatal(1, "timeout");
  end

endmodule
